seg_reader: RTL and testbench

// Reads back a multiplexed, active-low 7-segment display bus and recovers the hex digit

---
 rtl/seg_reader.sv | 266 ++++++++++++++++++++++++++
 tb/tb_seg_reader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_reader.sv
// -----------------------------------------------------------------------------
// seg_reader
// Reads back a multiplexed, active-low 7-segment display bus and recovers the
// hex digit shown in each digit position (inverse of a nibble-to-segment
// decoder). The bus is synchronized, must stay stable for STABLE_CYC samples
// before a capture, and patterns that are not hex glyphs are flagged.
//
// Parameters
//   NDIG        number of digit positions (anode lines), 1..8
//   STABLE_CYC  identical synchronized samples needed before capture, 2..255
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   seg      in   [6:0] segment lines, active-low, seg[0]=a .. seg[6]=g
//   dp       in   decimal point, active-low
//   an       in   [NDIG-1:0] anode selects, active-low, one-hot-low is legal
//   digits   out  [4*NDIG-1:0] recovered nibble per position
//   valid    out  [NDIG-1:0] position holds a legal captured glyph
//   upd      out  one-cycle strobe, a capture updated a position
//   upd_idx  out  [2:0] position of the current upd
//   err      out  one-cycle strobe, captured pattern is not a hex glyph
//   dp_out   out  [NDIG-1:0] captured decimal point per position
//                 (only when SEG_READER_DP_EN is defined)
//
// Optional feature macro: SEG_READER_DP_EN
// -----------------------------------------------------------------------------
module seg_reader #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg,
    input  logic                dp,
    input  logic [NDIG-1:0]     an,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     valid,
    output logic                upd,
    output logic [2:0]          upd_idx,
`ifdef SEG_READER_DP_EN
    output logic [NDIG-1:0]     dp_out,
`endif
    output logic                err
);

    localparam int          SW      = NDIG + 8;
    localparam logic [7:0]  CAP_CNT = 8'(STABLE_CYC - 1);
    localparam logic [7:0]  SAT_CNT = 8'(STABLE_CYC);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Legal anode pattern: exactly one line driven low.
    function automatic logic an_legal(input logic [NDIG-1:0] a);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (a[i] == 1'b0) begin
                n = n + 4'd1;
            end
        end
        return (n == 4'd1);
    endfunction

    // Index of the low anode line (only meaningful for a legal pattern).
    function automatic logic [2:0] an_index(input logic [NDIG-1:0] a);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (a[i] == 1'b0) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Segment pattern to {glyph_ok, blank, nibble}.
    function automatic logic [5:0] seg_decode(input logic [6:0] s);
        logic [5:0] r;
        case (s)
            7'h40:   r = {2'b10, 4'h0};
            7'h79:   r = {2'b10, 4'h1};
            7'h24:   r = {2'b10, 4'h2};
            7'h30:   r = {2'b10, 4'h3};
            7'h19:   r = {2'b10, 4'h4};
            7'h12:   r = {2'b10, 4'h5};
            7'h02:   r = {2'b10, 4'h6};
            7'h78:   r = {2'b10, 4'h7};
            7'h00:   r = {2'b10, 4'h8};
            7'h18:   r = {2'b10, 4'h9};
            7'h08:   r = {2'b10, 4'hA};
            7'h03:   r = {2'b10, 4'hB};
            7'h46:   r = {2'b10, 4'hC};
            7'h21:   r = {2'b10, 4'hD};
            7'h06:   r = {2'b10, 4'hE};
            7'h0E:   r = {2'b10, 4'hF};
            7'h7F:   r = {2'b01, 4'h0};
            default: r = {2'b00, 4'h0};
        endcase
        return r;
    endfunction

    logic [SW-1:0]      sync1_r;
    logic [SW-1:0]      sync2_r;
    logic [SW-1:0]      prev_r;
    logic [7:0]         count_r;
    state_t             state_r;
    state_t             next_state_s;
    logic               capture_s;
    logic               clr_cnt_s;
    logic               match_s;
    logic               legal_s;
    logic [2:0]         pos_s;
    logic [NDIG-1:0]    an_s;
    logic [6:0]         seg_s;
    logic [5:0]         dec_s;
    logic               dec_ok_s;
    logic               dec_blank_s;
    logic [3:0]         dec_nib_s;
    logic [4*NDIG-1:0]  digits_r;
    logic [NDIG-1:0]    valid_r;
    logic               upd_r;
    logic [2:0]         upd_idx_r;
    logic               err_r;

    assign an_s        = sync2_r[SW-1:8];
    assign seg_s       = sync2_r[7:1];
    assign match_s     = (sync2_r == prev_r);
    assign legal_s     = an_legal(an_s);
    assign pos_s       = an_index(an_s);
    assign dec_s       = seg_decode(seg_s);
    assign dec_ok_s    = dec_s[5];
    assign dec_blank_s = dec_s[4];
    assign dec_nib_s   = dec_s[3:0];

    // Two-flop synchronizer plus previous-sample register for the stability compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '1;
            sync2_r <= '1;
            prev_r  <= '1;
        end else begin
            sync1_r <= {an, seg, dp};
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Stability counter: cleared on any sample change or on entry to TRACK, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 8'd0;
        end else if (clr_cnt_s || !match_s) begin
            count_r <= 8'd0;
        end else if (count_r != SAT_CNT) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_WAIT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state and capture decision.
    always_comb begin
        next_state_s = state_r;
        capture_s    = 1'b0;
        clr_cnt_s    = 1'b0;
        case (state_r)
            ST_WAIT: begin
                if (legal_s) begin
                    next_state_s = ST_TRACK;
                    clr_cnt_s    = 1'b1;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_TRACK: begin
                if (!legal_s) begin
                    next_state_s = ST_WAIT;
                end else if (match_s && (count_r == CAP_CNT)) begin
                    // Count reaches STABLE_CYC-1 on this edge: capture now.
                    capture_s    = 1'b1;
                    next_state_s = ST_HOLD;
                end else begin
                    next_state_s = ST_TRACK;
                end
            end
            ST_HOLD: begin
                if (!legal_s) begin
                    next_state_s = ST_WAIT;
                end else if (!match_s) begin
                    next_state_s = ST_TRACK;
                    clr_cnt_s    = 1'b1;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            default: begin
                next_state_s = ST_WAIT;
            end
        endcase
    end

    // Capture registers: only the addressed position is written; strobes last one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_r  <= '0;
            valid_r   <= '0;
            upd_r     <= 1'b0;
            upd_idx_r <= 3'd0;
            err_r     <= 1'b0;
        end else begin
            upd_r <= capture_s;
            err_r <= capture_s && !dec_ok_s && !dec_blank_s;
            if (capture_s) begin
                upd_idx_r <= pos_s;
            end
            for (int i = 0; i < NDIG; i++) begin
                if (capture_s && (pos_s == 3'(i))) begin
                    if (dec_ok_s) begin
                        digits_r[4*i +: 4] <= dec_nib_s;
                    end
                    valid_r[i] <= dec_ok_s;
                end
            end
        end
    end

`ifdef SEG_READER_DP_EN
    logic [NDIG-1:0] dp_out_r;

    // Decimal point of the captured position, converted to active-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_out_r <= '0;
        end else begin
            for (int i = 0; i < NDIG; i++) begin
                if (capture_s && (pos_s == 3'(i))) begin
                    dp_out_r[i] <= ~sync2_r[0];
                end
            end
        end
    end

    assign dp_out = dp_out_r;
`endif

    assign digits  = digits_r;
    assign valid   = valid_r;
    assign upd     = upd_r;
    assign upd_idx = upd_idx_r;
    assign err     = err_r;

endmodule

// File: tb/tb_seg_reader.sv
// -----------------------------------------------------------------------------
// tb_seg_reader
// Directed stimulus for seg_reader (NDIG=4, STABLE_CYC=8). Each applied
// vector that should produce a capture pushes its expected response into a
// scoreboard queue; a monitor pops and compares on every upd strobe,
// including the exact cycle the strobe is expected.
// -----------------------------------------------------------------------------
module tb_seg_reader;

    localparam int NDIG = 4;
    localparam int SC   = 8;

    typedef struct {
        logic [2:0]  idx;
        logic        err;
        logic [15:0] digits;
        logic [3:0]  valid;
        logic [3:0]  dpo;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic        upd;
    logic [2:0]  upd_idx;
    logic        err;
`ifdef SEG_READER_DP_EN
    logic [3:0]  dp_out;
`endif

    int          total;
    int          bad;
    int          cyc;
    exp_t        sb[$];
    logic [15:0] m_digits;
    logic [3:0]  m_valid;
    logic [3:0]  m_dpo;
    logic [6:0]  glyphs[16];

    seg_reader #(.NDIG(NDIG), .STABLE_CYC(SC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg     (seg),
        .dp      (dp),
        .an      (an),
        .digits  (digits),
        .valid   (valid),
        .upd     (upd),
        .upd_idx (upd_idx),
`ifdef SEG_READER_DP_EN
        .dp_out  (dp_out),
`endif
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // kind: 0 glyph, 1 blank, 2 bad pattern, 3 no capture expected
    task automatic apply(input logic [3:0] a, input logic [6:0] s, input logic d,
                         input int hold, input int kind, input logic [3:0] nib);
        exp_t e;
        int   p;
        an  = a;
        seg = s;
        dp  = d;
        if (kind != 3) begin
            p = 0;
            for (int i = 0; i < NDIG; i++) begin
                if (a[i] == 1'b0) p = i;
            end
            if (kind == 0) begin
                m_digits[4*p +: 4] = nib;
                m_valid[p]         = 1'b1;
            end else begin
                m_valid[p] = 1'b0;
            end
            m_dpo[p] = ~d;
            e.idx    = 3'(p);
            e.err    = (kind == 2);
            e.digits = m_digits;
            e.valid  = m_valid;
            e.dpo    = m_dpo;
            e.cyc    = cyc + SC + 3;
            sb.push_back(e);
        end
        repeat (hold) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_digits"}, 32'(digits), 32'h0);
        chk({tag, "_valid"}, 32'(valid), 32'h0);
        chk({tag, "_upd"}, 32'(upd), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_upd_idx"}, 32'(upd_idx), 32'h0);
    endtask

    // Monitor: compare every upd strobe against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (upd === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_upd", 32'(upd_idx), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("upd_cycle", 32'(cyc), 32'(e.cyc));
                    chk("upd_idx", 32'(upd_idx), 32'(e.idx));
                    chk("err", 32'(err), 32'(e.err));
                    chk("digits", 32'(digits), 32'(e.digits));
                    chk("valid", 32'(valid), 32'(e.valid));
`ifdef SEG_READER_DP_EN
                    chk("dp_out", 32'(dp_out), 32'(e.dpo));
`endif
                end
            end else if (err !== 1'b0) begin
                chk("err_without_upd", 32'(err), 32'h0);
            end
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        m_digits = 16'h0;
        m_valid  = 4'h0;
        m_dpo    = 4'h0;
        glyphs = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                   7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst_n = 1'b0;
        an    = 4'b1111;
        seg   = 7'h7F;
        dp    = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single digit 2 on position 0, held long: exactly one capture.
        apply(4'b1110, 7'h24, 1'b1, 40, 0, 4'h2);
        // Full glyph table on position 0.
        for (int n = 0; n < 16; n++) begin
            apply(4'b1110, glyphs[n], 1'b1, 12, 0, 4'(n));
        end
        // F on position 3, then blank keeps the nibble but clears valid.
        apply(4'b0111, 7'h0E, 1'b1, 20, 0, 4'hF);
        apply(4'b0111, 7'h7F, 1'b1, 20, 1, 4'h0);
        // Non-glyph on position 1.
        apply(4'b1101, 7'h55, 1'b1, 20, 2, 4'h0);
        // A dp change alone re-captures the same glyph.
        apply(4'b1011, 7'h12, 1'b1, 12, 0, 4'h5);
        apply(4'b1011, 7'h12, 1'b0, 12, 0, 4'h5);
        // Toggling faster than the stability window never captures.
        for (int n = 0; n < 8; n++) begin
            apply(4'b1011, (n % 2 == 0) ? 7'h40 : 7'h79, 1'b1, 6, 3, 4'h0);
        end
        // Two anodes low, then none low: WAIT, no capture.
        apply(4'b1001, 7'h40, 1'b1, 30, 3, 4'h0);
        apply(4'b1111, 7'h40, 1'b1, 15, 3, 4'h0);
        chk("pre_reset_digits", 32'(digits), 32'(m_digits));
        chk("pre_reset_valid", 32'(valid), 32'(m_valid));

        // Reset in the middle of a capture window.
        apply(4'b1110, 7'h30, 1'b1, 5, 3, 4'h0);
        rst_n = 1'b0;
        #1;
        check_reset_state("midrun_reset");
        m_digits = 16'h0;
        m_valid  = 4'h0;
        m_dpo    = 4'h0;
        an       = 4'b1111;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("after_reset_valid", 32'(valid), 32'h0);

        // Scan showing 12AF, dp lit on position 2.
        apply(4'b1110, 7'h79, 1'b1, 20, 0, 4'h1);
        apply(4'b1101, 7'h24, 1'b1, 20, 0, 4'h2);
        apply(4'b1011, 7'h08, 1'b0, 20, 0, 4'hA);
        apply(4'b0111, 7'h0E, 1'b1, 20, 0, 4'hF);
        apply(4'b1111, 7'h7F, 1'b1, 20, 3, 4'h0);

        chk("scan_digits", 32'(digits), 32'h0000_FA21);
        chk("scan_valid", 32'(valid), 32'hF);
`ifdef SEG_READER_DP_EN
        chk("scan_dp_out", 32'(dp_out), 32'h4);
`endif
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
